// File: rtl/ex_wb_pipe_stage.sv
// ex_wb_pipe_stage: EX->WB pipeline register with valid/ready handshake,
// 2-entry skid buffer and synchronous flush.
//
// Handshake: an entry moves in when in_valid && in_ready, and moves out
// when out_valid && out_ready. in_ready is registered (no combinational
// path from out_ready); out_valid never drops without a transfer or flush.
//
// Optional feature: define PL_STALL_CNT_EN to add the stall_cnt port,
// a saturating count of cycles where WB holds off a valid entry.
module ex_wb_pipe_stage #(
    parameter int OP_W   = 4,
    parameter int RD_W   = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_opcode,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_rf_wr,
    input  logic              in_rf_wr_sel,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_opcode,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_rf_wr,
    output logic              out_rf_wr_sel,
`ifdef PL_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic [1:0]        state_dbg
);

    // Payload layout: {opcode, rd, data, rf_wr, rf_wr_sel}
    localparam int PL_W = OP_W + RD_W + DATA_W + 2;

    // EMPTY: nothing held. FULL: main only. SKID: main and skid both held,
    // so the SKID state itself is the skid register's valid bit.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t          state;
    logic [PL_W-1:0] main_pl;
    logic [PL_W-1:0] skid_pl;
    logic [PL_W-1:0] in_pl;
    logic            main_valid;
    logic            in_ready_q;
    logic            in_xfer;
    logic            out_xfer;

    assign in_pl    = {in_opcode, in_rd, in_data, in_rf_wr, in_rf_wr_sel};
    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = main_valid && out_ready;

    // Occupancy FSM: moves payloads between input, main and skid registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            main_pl    <= '0;
            skid_pl    <= '0;
            main_valid <= 1'b0;
            in_ready_q <= 1'b0;
        end else if (flush) begin
            // Held entries and any entry accepted this cycle are discarded.
            state      <= EMPTY;
            main_valid <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (in_xfer) begin
                        main_pl    <= in_pl;
                        main_valid <= 1'b1;
                        state      <= FULL;
                    end
                end
                FULL: begin
                    if (out_xfer && in_xfer) begin
                        main_pl <= in_pl;
                    end else if (out_xfer) begin
                        main_valid <= 1'b0;
                        state      <= EMPTY;
                    end else if (in_xfer) begin
                        // WB stalled: park the new entry and stop accepting.
                        skid_pl    <= in_pl;
                        in_ready_q <= 1'b0;
                        state      <= SKID;
                    end
                end
                SKID: begin
                    if (out_xfer) begin
                        main_pl    <= skid_pl;
                        in_ready_q <= 1'b1;
                        state      <= FULL;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    main_valid <= 1'b0;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = main_valid;
    assign out_opcode    = main_pl[PL_W-1 -: OP_W];
    assign out_rd        = main_pl[DATA_W+2 +: RD_W];
    assign out_data      = main_pl[2 +: DATA_W];
    // A bubble must never write the register file.
    assign out_rf_wr     = main_pl[1] & main_valid;
    assign out_rf_wr_sel = main_pl[0];
    assign state_dbg     = state;

`ifdef PL_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Count cycles where a valid entry waits on WB; saturate, clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (main_valid && !out_ready && !flush && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_wb_pipe_stage.sv
// Testbench for ex_wb_pipe_stage: queue-based reference model, directed
// scenarios followed by randomized traffic. Define PL_STALL_CNT_EN to also
// exercise the stall counter.
module tb_ex_wb_pipe_stage;

    localparam int OP_W   = 4;
    localparam int RD_W   = 4;
    localparam int DATA_W = 16;
    localparam int ENT_W  = OP_W + RD_W + DATA_W + 2;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
        logic              wr;
        logic              sel;
    } entry_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [OP_W-1:0]   in_opcode = '0;
    logic [RD_W-1:0]   in_rd = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_rf_wr = 1'b0;
    logic              in_rf_wr_sel = 1'b0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OP_W-1:0]   out_opcode;
    logic [RD_W-1:0]   out_rd;
    logic [DATA_W-1:0] out_data;
    logic              out_rf_wr;
    logic              out_rf_wr_sel;
    logic [1:0]        state_dbg;
`ifdef PL_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    ex_wb_pipe_stage #(.OP_W(OP_W), .RD_W(RD_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_rd         (in_rd),
        .in_data       (in_data),
        .in_rf_wr      (in_rf_wr),
        .in_rf_wr_sel  (in_rf_wr_sel),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_opcode    (out_opcode),
        .out_rd        (out_rd),
        .out_data      (out_data),
        .out_rf_wr     (out_rf_wr),
        .out_rf_wr_sel (out_rf_wr_sel),
`ifdef PL_STALL_CNT_EN
        .stall_cnt     (stall_cnt),
`endif
        .state_dbg     (state_dbg)
    );

    // ---------------- scoreboard / model ----------------
    logic [ENT_W-1:0] exp_q[$];
    logic [15:0]      exp_stall = '0;
    bit               just_released = 1'b0;
    int               checks = 0;
    int               failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [ENT_W-1:0] mk(input logic [15:0] d, input logic wr);
        entry_t e;
        e.op   = d[3:0] ^ 4'h5;
        e.rd   = d[7:4];
        e.data = d;
        e.wr   = wr;
        e.sel  = d[8];
        return e;
    endfunction

    function automatic logic [ENT_W-1:0] rnd_entry();
        return ENT_W'($urandom);
    endfunction

    // Compare all DUT outputs against the model's view of the current cycle.
    task automatic check_outputs();
        entry_t e;
        int n;
        n = exp_q.size();
        check("in_ready", 32'(in_ready), 32'(!just_released && n < 2));
        check("out_valid", 32'(out_valid), 32'(n > 0));
        if (n > 0) begin
            e = exp_q[0];
            check("out_opcode", 32'(out_opcode), 32'(e.op));
            check("out_rd", 32'(out_rd), 32'(e.rd));
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_rf_wr", 32'(out_rf_wr), 32'(e.wr));
            check("out_rf_wr_sel", 32'(out_rf_wr_sel), 32'(e.sel));
        end else begin
            check("out_rf_wr_bubble", 32'(out_rf_wr), 32'd0);
        end
`ifdef PL_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`endif
    endtask

    // ---------------- driver ----------------
    // One clock cycle: drive, check, advance model across the edge.
    task automatic step(input bit v, input logic [ENT_W-1:0] p, input bit ordy, input bit fl);
        bit in_x;
        bit out_x;
        bit stall_inc;
        in_valid = v;
        {in_opcode, in_rd, in_data, in_rf_wr, in_rf_wr_sel} = p;
        out_ready = ordy;
        flush = fl;
        #1;
        check_outputs();
        in_x      = v && !just_released && exp_q.size() < 2;
        out_x     = ordy && exp_q.size() > 0;
        stall_inc = !fl && !ordy && exp_q.size() > 0 && exp_stall != 16'hFFFF;
        @(posedge clk);
        #1;
        just_released = 1'b0;
        if (stall_inc) exp_stall++;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (out_x) void'(exp_q.pop_front());
            if (in_x) exp_q.push_back(p);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_rf_wr"}, 32'(out_rf_wr), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_out_opcode"}, 32'(out_opcode), 32'd0);
        check({tag, "_out_rd"}, 32'(out_rd), 32'd0);
        check({tag, "_out_sel"}, 32'(out_rf_wr_sel), 32'd0);
`ifdef PL_STALL_CNT_EN
        check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
`endif
    endtask

    // Asynchronous reset in the middle of a cycle, released away from an edge.
    task automatic mid_reset();
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_stall = '0;
        just_released = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [ENT_W-1:0] p;

        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'($urandom);
            {in_opcode, in_rd, in_data, in_rf_wr, in_rf_wr_sel} = rnd_entry();
            out_ready = 1'($urandom);
            flush = 1'($urandom);
            @(posedge clk);
            #1;
            check_reset_values("reset");
        end
        rst = 1'b0;
        just_released = 1'b1;
        step(1'b0, '0, 1'b1, 1'b0);
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        check("post_reset_out_valid", 32'(out_valid), 32'd0);

        // Streaming: 8 back-to-back entries, one cycle latency, no bubbles.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, mk(16'(i), 1'b1), 1'b1, 1'b0);
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_data", 32'(out_data), 32'(i));
        end
        step(1'b0, '0, 1'b1, 1'b0);

        // Back-pressure into the skid register.
        step(1'b1, mk(16'hA5A5, 1'b1), 1'b0, 1'b0);
        step(1'b1, mk(16'h5A5A, 1'b0), 1'b0, 1'b0);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_hold_data", 32'(out_data), 32'hA5A5);
        step(1'b0, '0, 1'b1, 1'b0);
        check("bp_drain_second", 32'(out_data), 32'h5A5A);
        check("bp_in_ready_back", 32'(in_ready), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("bp_empty", 32'(out_valid), 32'd0);

        // Flush while in SKID with a simultaneous input.
        step(1'b1, mk(16'h1111, 1'b1), 1'b0, 1'b0);
        step(1'b1, mk(16'h2222, 1'b1), 1'b0, 1'b0);
        step(1'b1, mk(16'hBEEF, 1'b1), 1'b0, 1'b1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_out_rf_wr", 32'(out_rf_wr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            check("flush_no_beef", 32'(out_valid && out_data == 16'hBEEF), 32'd0);
        end

        // Bubble gating: rf_wr set without in_valid.
        step(1'b0, mk(16'h0F0F, 1'b1), 1'b1, 1'b0);
        check("bubble_rf_wr", 32'(out_rf_wr), 32'd0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 1500; i++) begin
            p = rnd_entry();
            step(1'($urandom), p, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end

        // Reset mid-operation.
        step(1'b1, rnd_entry(), 1'b0, 1'b0);
        step(1'b1, rnd_entry(), 1'b0, 1'b0);
        mid_reset();
        step(1'b1, rnd_entry(), 1'b1, 1'b0);
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom), rnd_entry(), 1'($urandom), $urandom_range(0, 29) == 0);
        end

`ifdef PL_STALL_CNT_EN
        // Stall counter: 5 stalled cycles, then run to saturation.
        mid_reset();
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, mk(16'h1234, 1'b1), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0);
        check("stall_five", 32'(stall_cnt), 32'd5);
        for (int i = 0; i < 65529; i++) step(1'b0, '0, 1'b0, 1'b0);
        check("stall_fffe", 32'(stall_cnt), 32'hFFFE);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
        check("stall_saturate", 32'(stall_cnt), 32'hFFFF);
        step(1'b0, '0, 1'b1, 1'b0);
`endif

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
